// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_pkg : shared types and constants for the counter sequencer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package counter_pkg;

  localparam int CFG_W      = 8;
  localparam int CFG_PASS_W = 8;
  localparam int STEP_MIN   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [CFG_W-1:0]      start;
    logic [CFG_W-1:0]      limit;
    logic [CFG_W-1:0]      step;
    logic [CFG_PASS_W-1:0] passes;
  } cfg_t;

endpackage
`default_nettype wire

// File: rtl/counter_datapath.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_datapath : count register, widened adder and limit compare   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module counter_datapath
  import counter_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic         advance_i,
  input  logic [W-1:0] load_val_i,
  input  logic [W-1:0] step_i,
  input  logic [W-1:0] limit_i,
  output logic [W-1:0] count_o,
  output logic         last_raw_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  logic [W-1:0] step_eff;
  logic [W:0]   nxt;

  always_comb begin
    step_eff = step_i;
    if (step_i == '0) begin
      step_eff = W'(STEP_MIN);
    end
  end

  // Carry bit is kept so that an overflowing sum reads as past the limit.
  assign nxt        = {1'b0, count_q} + {1'b0, step_eff};
  assign last_raw_o = (nxt > {1'b0, limit_i});

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (advance_i) begin
      count_d = nxt[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/counter_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | counter_sequencer : config latch and run FSM for the counter datapath|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int W      = CFG_W,
  parameter int PASS_W = CFG_PASS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [W-1:0]      cfg_start,
  input  logic [W-1:0]      cfg_limit,
  input  logic [W-1:0]      cfg_step,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              start,
  input  logic              en,
  input  logic              pause,
  input  logic              abort,
  output logic [W-1:0]      count,
  output logic              busy,
  output logic              last,
  output logic              done
);

  seq_state_e        state_q;
  seq_state_e        state_d;
  cfg_t              cfg_q;
  cfg_t              cfg_d;
  logic [PASS_W-1:0] pass_q;
  logic [PASS_W-1:0] pass_d;

  logic              dp_clear;
  logic              dp_load;
  logic              dp_advance;
  logic              last_raw;
  logic [PASS_W-1:0] passes_cfg;

  assign passes_cfg = PASS_W'(cfg_q.passes);

  counter_datapath #(
    .W (W)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (dp_clear),
    .load_i     (dp_load),
    .advance_i  (dp_advance),
    .load_val_i (W'(cfg_q.start)),
    .step_i     (W'(cfg_q.step)),
    .limit_i    (W'(cfg_q.limit)),
    .count_o    (count),
    .last_raw_o (last_raw)
  );

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    pass_d     = pass_q;
    dp_clear   = 1'b0;
    dp_load    = 1'b0;
    dp_advance = 1'b0;

    case (state_q)
      IDLE: begin
        // The load below uses cfg_q, so a config accepted alongside start
        // only takes effect on the following run.
        if (cfg_valid) begin
          cfg_d.start  = CFG_W'(cfg_start);
          cfg_d.limit  = CFG_W'(cfg_limit);
          cfg_d.step   = CFG_W'(cfg_step);
          cfg_d.passes = CFG_PASS_W'(cfg_passes);
        end
        if (start) begin
          state_d = RUN;
          dp_load = 1'b1;
          pass_d  = passes_cfg;
        end
      end

      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          dp_clear = 1'b1;
        end else if (pause) begin
          state_d = PAUSE;
        end else if (en) begin
          if (!last_raw) begin
            dp_advance = 1'b1;
          end else if (passes_cfg == '0) begin
            dp_load = 1'b1;
          end else if (pass_q > PASS_W'(1)) begin
            dp_load = 1'b1;
            pass_d  = pass_q - PASS_W'(1);
          end else begin
            state_d = DONE;
          end
        end
      end

      PAUSE: begin
        if (abort) begin
          state_d  = IDLE;
          dp_clear = 1'b1;
        end else if (!pause) begin
          state_d = RUN;
        end
      end

      DONE: begin
        state_d = IDLE;
        if (abort) begin
          dp_clear = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cfg_q.start  <= '0;
      cfg_q.limit  <= '0;
      cfg_q.step   <= CFG_W'(STEP_MIN);
      cfg_q.passes <= CFG_PASS_W'(1);
      pass_q       <= '0;
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      pass_q  <= pass_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign last      = ((state_q == RUN) || (state_q == PAUSE)) && last_raw;

endmodule
`default_nettype wire

// File: tb/tb_counter_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_counter_sequencer : scoreboard bench with a behavioural model     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_counter_sequencer;

  localparam int W      = 8;
  localparam int PASS_W = 8;

  logic              clk;
  logic              rst;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [W-1:0]      cfg_start;
  logic [W-1:0]      cfg_limit;
  logic [W-1:0]      cfg_step;
  logic [PASS_W-1:0] cfg_passes;
  logic              start;
  logic              en;
  logic              pause;
  logic              abort;
  logic [W-1:0]      count;
  logic              busy;
  logic              last;
  logic              done;

  counter_sequencer #(
    .W      (W),
    .PASS_W (PASS_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_start  (cfg_start),
    .cfg_limit  (cfg_limit),
    .cfg_step   (cfg_step),
    .cfg_passes (cfg_passes),
    .start      (start),
    .en         (en),
    .pause      (pause),
    .abort      (abort),
    .count      (count),
    .busy       (busy),
    .last       (last),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int count;
    bit busy;
    bit last;
    bit done;
    bit ready;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: mode 0=idle, 1=counting, 2=held, 3=finished.
  int m_mode  = 0;
  int m_cnt   = 0;
  int m_start = 0;
  int m_limit = 0;
  int m_step  = 1;
  int m_passes = 1;
  int m_left  = 0;

  function automatic int eff_step();
    return (m_step == 0) ? 1 : m_step;
  endfunction

  task automatic model_edge();
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_left = 0;
      m_start = 0; m_limit = 0; m_step = 1; m_passes = 1;
    end else if (m_mode == 0) begin
      if (start) begin
        m_mode = 1;
        m_cnt  = m_start;
        m_left = m_passes;
      end
      if (cfg_valid) begin
        m_start  = int'(cfg_start);
        m_limit  = int'(cfg_limit);
        m_step   = int'(cfg_step);
        m_passes = int'(cfg_passes);
      end
    end else if (abort) begin
      m_mode = 0;
      m_cnt  = 0;
    end else if (m_mode == 3) begin
      m_mode = 0;
    end else if (pause) begin
      m_mode = 2;
    end else if (m_mode == 2) begin
      m_mode = 1;
    end else if (en) begin
      if (m_cnt + eff_step() <= m_limit) begin
        m_cnt = m_cnt + eff_step();
      end else if (m_passes == 0) begin
        m_cnt = m_start;
      end else if (m_left > 1) begin
        m_cnt  = m_start;
        m_left = m_left - 1;
      end else begin
        m_mode = 3;
      end
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.count = m_cnt;
    e.busy  = (m_mode != 0);
    e.last  = (m_mode == 1 || m_mode == 2) && (m_cnt + eff_step() > m_limit);
    e.done  = (m_mode == 3);
    e.ready = (m_mode == 0);
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    push_expect();
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("count", int'(count), e.count);
      chk("busy", int'(busy), int'(e.busy));
      chk("last", int'(last), int'(e.last));
      chk("done", int'(done), int'(e.done));
      chk("cfg_ready", int'(cfg_ready), int'(e.ready));
    end
  end

  task automatic set_cfg(input int s, input int l, input int st, input int p);
    cfg_valid  = 1'b1;
    cfg_start  = W'(s);
    cfg_limit  = W'(l);
    cfg_step   = W'(st);
    cfg_passes = PASS_W'(p);
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; en = 1'b0;
    pause = 1'b0; abort = 1'b0;
    cfg_start = '0; cfg_limit = '0; cfg_step = '0; cfg_passes = '0;
    repeat (2) step();
    rst = 1'b0;
    step();

    // Free-running 0..10 wrap counter
    set_cfg(0, 10, 1, 0);
    en = 1'b1;
    go();
    repeat (24) step();
    abort = 1'b1; step(); abort = 1'b0;
    en = 1'b0; step();

    // Odd-number single pass ending at 99
    set_cfg(1, 100, 2, 1);
    en = 1'b1;
    go();
    repeat (52) step();
    en = 1'b0;

    // Pause hold then abort
    set_cfg(0, 10, 1, 1);
    en = 1'b1;
    go();
    for (int i = 0; i < 20 && m_cnt != 4; i++) step();
    pause = 1'b1; repeat (3) step(); pause = 1'b0;
    for (int i = 0; i < 20 && m_cnt != 7; i++) step();
    abort = 1'b1; step(); abort = 1'b0;
    en = 1'b0; step();

    // Zero step behaves as one, two passes
    set_cfg(0, 3, 0, 2);
    en = 1'b1;
    go();
    repeat (10) step();
    en = 1'b0;
    // Near-top start with large step, no wrap
    set_cfg(250, 255, 10, 1);
    en = 1'b1;
    go();
    repeat (4) step();
    // Sum overflows the width
    en = 1'b0;
    set_cfg(255, 255, 1, 1);
    en = 1'b1;
    go();
    repeat (3) step();
    en = 1'b0;

    // Config and start together: run uses the older start
    set_cfg(0, 4, 1, 1);
    cfg_valid = 1'b1; cfg_start = 8'd5; cfg_limit = 8'd9;
    cfg_step = 8'd1; cfg_passes = 8'd1; start = 1'b1;
    step();
    cfg_valid = 1'b0; start = 1'b0;
    en = 1'b1;
    repeat (10) step();
    go();
    repeat (3) step();
    rst = 1'b1; step(); rst = 1'b0;
    en = 1'b0; step();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      cfg_valid = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) begin
        cfg_start = W'($urandom_range(230, 255));
        cfg_limit = W'($urandom_range(240, 255));
        cfg_step  = W'($urandom_range(0, 20));
      end else begin
        cfg_start = W'($urandom_range(0, 23));
        cfg_limit = W'($urandom_range(0, 20));
        cfg_step  = W'($urandom_range(0, 4));
      end
      cfg_passes = PASS_W'($urandom_range(0, 3));
      start = ($urandom_range(0, 2) == 0);
      en    = ($urandom_range(0, 3) != 0);
      pause = ($urandom_range(0, 5) == 0);
      abort = ($urandom_range(0, 39) == 0);
      step();
    end
    rst = 1'b0; cfg_valid = 1'b0; start = 1'b0; en = 1'b0;
    pause = 1'b0; abort = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
